// File: rtl/quadrature_decoder_if.sv
// Encoder decoder bundle: sample strobe, raw channels and clear in; detent pulses, count, error out.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface quadrature_decoder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                          tick;
  logic                          in_a;
  logic                          in_b;
  logic                          clear;
  logic                          up_pulse;
  logic                          down_pulse;
  logic signed [COUNT_WIDTH-1:0] position;
  logic                          error;

  // Controller side: drives sampling strobe and raw encoder lines, observes results
  modport master (
    output tick, in_a, in_b, clear,
    input  up_pulse, down_pulse, position, error
  );

  // Decoder side
  modport slave (
    input  tick, in_a, in_b, clear,
    output up_pulse, down_pulse, position, error
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Rotary encoder decoder: sync + debounce A/B, Gray step tracking, detent pulses, saturating signed count.
// Latency: 2 clk synchronizer + DEBOUNCE_CYCLES ticks; pulse and count update one clk after the committing tick.
// Backpressure: none. Define QUADRATURE_DECODER_INVERT_EN to swap the direction sense.
module quadrature_decoder #(
  parameter int DEBOUNCE_CYCLES  = 7,
  parameter int STEPS_PER_DETENT = 4,
  parameter int COUNT_WIDTH      = 8
) (
  input logic                 clk,
  input logic                 rst,
  quadrature_decoder_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0] SPD  = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] NSPD = -SPD;
  localparam logic signed [COUNT_WIDTH-1:0] POS_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] POS_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

  typedef enum logic {INIT, TRACK} state_t;

  logic [1:0] sync_a_q, sync_b_q;
  logic       sync_a, sync_b;

  state_t                        state_q, state_d;
  logic                          com_a_q, com_a_d, com_b_q, com_b_d;
  logic [CW-1:0]                 cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CW-1:0]                 init_cnt_q, init_cnt_d;
  logic signed [3:0]             acc_q, acc_d;
  logic                          up_q, up_d, dn_q, dn_d;
  logic signed [COUNT_WIDTH-1:0] pos_q, pos_d;
  logic                          err_q, err_d;

  logic              chg_a, chg_b, fwd;
  logic signed [3:0] step, acc_sum;

  assign sync_a = sync_a_q[1];
  assign sync_b = sync_b_q[1];

  // Two-flop synchronizers for the asynchronous encoder lines, free-running on every clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
    end else begin
      sync_a_q <= {sync_a_q[0], bus.in_a};
      sync_b_q <= {sync_b_q[0], bus.in_b};
    end
  end

  // Next state: init stability wait, per-channel debounce, Gray step decode, detent accumulate, count
  always_comb begin
    state_d    = state_q;
    com_a_d    = com_a_q;
    com_b_d    = com_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    init_cnt_d = init_cnt_q;
    acc_d      = acc_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    pos_d      = pos_q;
    err_d      = err_q;
    chg_a      = 1'b0;
    chg_b      = 1'b0;
    fwd        = 1'b0;
    step       = 4'sd0;
    acc_sum    = acc_q;

    case (state_q)
      INIT: begin
        // Committed levels shadow the synchronizers until both hold steady long enough
        if (bus.tick) begin
          com_a_d = sync_a;
          com_b_d = sync_b;
          if (sync_a == com_a_q && sync_b == com_b_q) begin
            if (init_cnt_q == DB_LAST) begin
              init_cnt_d = '0;
              state_d    = TRACK;
            end else begin
              init_cnt_d = init_cnt_q + 1'b1;
            end
          end else begin
            init_cnt_d = '0;
          end
        end
      end

      TRACK: begin
        if (bus.tick) begin
          if (sync_a == com_a_q) begin
            cnt_a_d = '0;
          end else if (cnt_a_q == DB_LAST) begin
            com_a_d = sync_a;
            cnt_a_d = '0;
          end else begin
            cnt_a_d = cnt_a_q + 1'b1;
          end

          if (sync_b == com_b_q) begin
            cnt_b_d = '0;
          end else if (cnt_b_q == DB_LAST) begin
            com_b_d = sync_b;
            cnt_b_d = '0;
          end else begin
            cnt_b_d = cnt_b_q + 1'b1;
          end
        end

        chg_a = (com_a_d != com_a_q);
        chg_b = (com_b_d != com_b_q);
        // For a single-channel change, old A xor new B is 1 exactly on the 00->01->11->10 direction
`ifdef QUADRATURE_DECODER_INVERT_EN
        fwd = ~(com_a_q ^ com_b_d);
`else
        fwd = com_a_q ^ com_b_d;
`endif
        if (chg_a && chg_b) begin
          // Skipped a Gray state: direction unknown, drop the partial detent
          err_d = 1'b1;
          acc_d = 4'sd0;
        end else if (chg_a || chg_b) begin
          step    = fwd ? 4'sd1 : -4'sd1;
          acc_sum = acc_q + step;
          if (acc_sum == SPD) begin
            up_d  = 1'b1;
            acc_d = 4'sd0;
          end else if (acc_sum == NSPD) begin
            dn_d  = 1'b1;
            acc_d = 4'sd0;
          end else begin
            acc_d = acc_sum;
          end
        end
      end

      default: state_d = INIT;
    endcase

    if (up_d && pos_q != POS_MAX) pos_d = pos_q + 1'b1;
    if (dn_d && pos_q != POS_MIN) pos_d = pos_q - 1'b1;

    // Clear beats a same-cycle detent on the count; the pulse itself still goes out
    if (bus.clear) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      com_a_q    <= 1'b0;
      com_b_q    <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      init_cnt_q <= '0;
      acc_q      <= 4'sd0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      pos_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      com_a_q    <= com_a_d;
      com_b_q    <= com_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      init_cnt_q <= init_cnt_d;
      acc_q      <= acc_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
    end
  end

  assign bus.up_pulse   = up_q;
  assign bus.down_pulse = dn_q;
  assign bus.position   = pos_q;
  assign bus.error      = err_q;

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Decodes the front-panel rotary encoder (ENCODER_A/ENCODER_B) into clean single-cycle up/down detent pulses and a signed position count.
- Sits directly upstream of the input_state accumulator in top. Replaces the per-channel debounced_button edge detectors, which only catch half the required edges.
- Runs on system_clk[0]. Input sampling is paced by a slow tick strobe (one system_clk[0] cycle wide, derived from the prescaler).

Parameters:
- DEBOUNCE_CYCLES, 7, consecutive tick samples a channel must hold a new level before it is accepted
- STEPS_PER_DETENT, 4, valid Gray transitions per mechanical detent; legal values 1, 2, 4
- COUNT_WIDTH, 8, width of signed position output

Ports:
- clk  input  1  system clock (system_clk[0])
- rst  input  1  synchronous reset, active-high
- tick  input  1  sample enable, one clk cycle wide
- in_a  input  1  raw encoder channel A, asynchronous
- in_b  input  1  raw encoder channel B, asynchronous
- clear  input  1  zeroes position and error (driven from spi_value_valid)
- up_pulse  output  1  one-cycle pulse per clockwise detent
- down_pulse  output  1  one-cycle pulse per counter-clockwise detent
- position  output  COUNT_WIDTH  signed detent count, saturating
- error  output  1  sticky: illegal double-channel transition seen

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high. Every register clears on the clk edge where rst=1.
- Reset values: up_pulse=0, down_pulse=0, position=0, error=0, FSM=INIT, sub-step accumulator=0, debounce counters=0.
- Synchronizer: in_a and in_b each pass through a 2-FF synchronizer on every clk, independent of tick.
- Debounce, per channel, evaluated only when tick=1:
  - Synced level equal to committed level: counter resets to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the new level commits on that tick and the counter resets.
- A channel flicker inside the window restarts its count.
- FSM INIT, entered after reset:
  - Committed levels load directly from the synchronizers once both have been stable for DEBOUNCE_CYCLES ticks.
  - No steps and no pulses are generated.
  - Transition to TRACK on the cycle after the load.
- FSM TRACK: on each cycle where one or both committed levels change, compare the old {A,B} with the new {A,B}.
  - Sequence 00->01->11->10->00 is +1; the reverse is -1.
  - Both channels changing in the same cycle sets error=1 (sticky), forces accumulator=0, generates no pulse, and stays in TRACK.
- Sub-step accumulator: signed, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1).
  - Reaching +STEPS_PER_DETENT: up_pulse=1 for exactly one clk, accumulator=0.
  - Reaching -STEPS_PER_DETENT: down_pulse=1 for one clk, accumulator=0.
  - A direction reversal mid-detent simply counts back toward 0.
- Latency: the pulse is asserted on the clk cycle after the committing tick.
- position:
  - +1 per up_pulse and -1 per down_pulse, in the same cycle the pulse is asserted.
  - Saturates at 2^(COUNT_WIDTH-1)-1 and -2^(COUNT_WIDTH-1); no wrap.
- clear:
  - Zeroes position and error on that clk.
  - If clear coincides with a pulse, the pulse is still output and position ends at 0 (clear wins).
  - The accumulator is not affected by clear.
- up_pulse and down_pulse are never high simultaneously.
- rst mid-detent: accumulator is discarded and the FSM returns to INIT; no spurious pulse after reset.

Optional Feature:
- Macro QUADRATURE_DECODER_INVERT_EN.
- Defined: the direction sense is swapped. Sequence 00->01->11->10 produces down_pulse and a decrementing position. Use this for encoders wired with A/B reversed.
- Undefined: direction as specified in Behaviour.
- Error detection, saturation and latency are identical in both builds.

Test Plan:
- Reset, hold in_a=1, in_b=1 for 10 ticks -> FSM reaches TRACK with committed AB=11; no pulses; position=0; error=0.
- From AB=00, apply one full CW cycle 01,11,10,00, each level held 8 ticks (STEPS_PER_DETENT=4) -> exactly one up_pulse, one clk wide, one cycle after the 4th commit; position=1.
- Apply 3 CW steps, then 3 CCW steps -> no pulse; position unchanged; accumulator back to 0.
- Toggle in_a for 3 ticks then return, repeatedly -> no commit, no pulse (debounce rejects glitches shorter than 7 ticks).
- Change AB 00->11 in the same tick -> error=1 and no pulse. Then assert clear -> error=0, position=0.
- Apply 130 CW detents with COUNT_WIDTH=8 -> position saturates at 127 while up_pulse keeps firing. Then apply clear in the same cycle as an up_pulse -> position=0, up_pulse still seen.
